// File: rtl/write_datapath.sv
`default_nettype none
// ============================================================================
// Module   : write_datapath
// Purpose  : ESDI write-data receiver. Generates the NRZ write clock, samples
//            synchronized write data while write gate is open, packs it
//            MSB-first into bytes and streams them out tagged with the sector.
// Revision : 1.0  initial release
// ============================================================================
module write_datapath #(
    parameter int DEFAULT_HALFBIT = 5
) (
    input  logic        csr_aclk,
    input  logic        csr_aresetn,
    input  logic        csr_awvalid,
    output logic        csr_awready,
    input  logic [4:0]  csr_awaddr,
    input  logic [2:0]  csr_awprot,
    input  logic        csr_wvalid,
    output logic        csr_wready,
    input  logic [31:0] csr_wdata,
    input  logic [3:0]  csr_wstrb,
    output logic        csr_bvalid,
    input  logic        csr_bready,
    output logic [1:0]  csr_bresp,
    input  logic        csr_arvalid,
    output logic        csr_arready,
    input  logic [4:0]  csr_araddr,
    input  logic [2:0]  csr_arprot,
    output logic        csr_rvalid,
    input  logic        csr_rready,
    output logic [31:0] csr_rdata,
    output logic [1:0]  csr_rresp,
    output logic        parallel_tvalid,
    input  logic        parallel_tready,
    output logic [7:0]  parallel_tdata,
    output logic        parallel_tlast,
    output logic [7:0]  parallel_tid,
    input  logic [7:0]  sector_number,
    input  logic        esdi_write_gate,
    input  logic        esdi_write_data,
    output logic        esdi_write_clock
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // CSR storage and AXI-Lite holds
    logic        aw_full, w_full;
    logic [2:0]  aw_idx;
    logic [6:0]  wdata_q;
    logic [1:0]  control;
    logic [1:0]  status;
    logic [6:0]  clocks_per_halfbit;
    logic [15:0] last_byte_count;
    logic        do_write;
    logic [31:0] rd_mux;

    // Clock generator
    logic [7:0]  cnt;
    logic [7:0]  h_ext, half_end, full_end;
    logic        strobe;

    // Synchronizers
    logic [1:0]  gate_sync, data_sync;
    logic        gate_s, data_s, gate_q;

    // Deserializer state
    state_t      state;
    logic [6:0]  shreg;
    logic [2:0]  bit_cnt, bits_next;
    logic [7:0]  tid_q, pend_data, new_byte;
    logic        pend_valid, flush;
    logic [15:0] byte_cnt, byte_total;
    logic        active, sample, complete, gate_rise, gate_fall;
    logic        issue, issue_last, can_load, set_overflow, set_partial;

    logic        unused_inputs;
    assign unused_inputs = ^{csr_awaddr[1:0], csr_araddr[1:0], csr_awprot,
                             csr_arprot, csr_wstrb, csr_wdata[31:7]};

    assign csr_awready = !aw_full;
    assign csr_wready  = !w_full;
    assign csr_arready = !csr_rvalid || csr_rready;
    assign csr_bresp   = 2'b00;
    assign csr_rresp   = 2'b00;
    assign do_write    = aw_full && w_full && (!csr_bvalid || csr_bready);

    assign h_ext    = {1'b0, clocks_per_halfbit};
    assign half_end = h_ext - 8'd1;
    assign full_end = (h_ext << 1) - 8'd1;
    assign strobe   = (cnt == half_end);

    assign gate_s    = gate_sync[1];
    assign data_s    = data_sync[1];
    assign active    = (state != IDLE);
    assign sample    = active && strobe;
    assign complete  = sample && (state == SHIFT) && (bit_cnt == 3'd7);
    assign new_byte  = {shreg, data_s};
    assign gate_rise = gate_s && !gate_q;
    assign gate_fall = active && gate_q && !gate_s;
    assign can_load  = !parallel_tvalid || parallel_tready;

    // Next bit count and window byte total including this cycle's completion
    always_comb begin
        bits_next  = bit_cnt;
        byte_total = byte_cnt;
        if (sample) begin
            if (state == HUNT) bits_next = data_s ? 3'd1 : 3'd0;
            else               bits_next = bit_cnt + 3'd1;
        end
        if (complete && (byte_cnt != 16'hFFFF)) byte_total = byte_cnt + 16'd1;
    end

    // Decide whether the pending byte leaves this cycle, and with which tlast
    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        if (flush) begin
            issue      = 1'b1;
            issue_last = 1'b1;
        end else if (complete && pend_valid) begin
            issue = 1'b1;
        end else if (gate_fall && pend_valid) begin
            issue      = 1'b1;
            issue_last = 1'b1;
        end
    end

    assign set_overflow = issue && !can_load;
    assign set_partial  = gate_fall && (bits_next != 3'd0);

    // Register read multiplexer
    always_comb begin
        rd_mux = 32'd0;
        case (csr_araddr[4:2])
            3'd0:    rd_mux = {30'd0, control};
            3'd1:    rd_mux = {30'd0, status};
            3'd2:    rd_mux = {25'd0, clocks_per_halfbit};
            3'd3:    rd_mux = {16'd0, last_byte_count};
            default: rd_mux = 32'd0;
        endcase
    end

    // AXI-Lite write path: independent AW/W holds, commit into registers
    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            aw_full            <= 1'b0;
            w_full             <= 1'b0;
            aw_idx             <= 3'd0;
            wdata_q            <= 7'd0;
            csr_bvalid         <= 1'b0;
            control            <= 2'd0;
            status             <= 2'd0;
            clocks_per_halfbit <= 7'(DEFAULT_HALFBIT);
        end else begin
            if (csr_awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_idx  <= csr_awaddr[4:2];
            end
            if (csr_wvalid && !w_full) begin
                w_full  <= 1'b1;
                wdata_q <= csr_wdata[6:0];
            end
            if (do_write) begin
                aw_full    <= 1'b0;
                w_full     <= 1'b0;
                csr_bvalid <= 1'b1;
                case (aw_idx)
                    3'd0:    control            <= wdata_q[1:0];
                    3'd1:    status             <= wdata_q[1:0];
                    3'd2:    clocks_per_halfbit <= wdata_q;
                    default: ;
                endcase
            end else if (csr_bready) begin
                csr_bvalid <= 1'b0;
            end
            // Hardware events take priority over a same-cycle software write
            if (set_overflow) status[0] <= 1'b1;
            if (set_partial)  status[1] <= 1'b1;
        end
    end

    // AXI-Lite read path with registered data
    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            csr_rvalid <= 1'b0;
            csr_rdata  <= 32'd0;
        end else if (csr_arvalid && csr_arready) begin
            csr_rvalid <= 1'b1;
            csr_rdata  <= rd_mux;
        end else if (csr_rready) begin
            csr_rvalid <= 1'b0;
        end
    end

    // Free-running half-bit counter producing the write clock
    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            cnt              <= 8'd0;
            esdi_write_clock <= 1'b0;
        end else if (cnt == full_end) begin
            cnt              <= 8'd0;
            esdi_write_clock <= 1'b0;
        end else begin
            cnt <= cnt + 8'd1;
            if (strobe) esdi_write_clock <= 1'b1;
        end
    end

    // Two-flop synchronizers for gate and data, plus gate edge history
    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            gate_sync <= 2'b00;
            data_sync <= 2'b00;
            gate_q    <= 1'b0;
        end else begin
            gate_sync <= {gate_sync[0], esdi_write_gate};
            data_sync <= {data_sync[0], esdi_write_data};
            gate_q    <= gate_s;
        end
    end

    // Window state machine, deserializer and pending-byte stage
    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            state           <= IDLE;
            shreg           <= 7'd0;
            bit_cnt         <= 3'd0;
            tid_q           <= 8'd0;
            pend_data       <= 8'd0;
            pend_valid      <= 1'b0;
            flush           <= 1'b0;
            byte_cnt        <= 16'd0;
            last_byte_count <= 16'd0;
        end else begin
            flush <= 1'b0;
            if (flush) pend_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gate_rise && control[1]) begin
                        state      <= control[0] ? HUNT : SHIFT;
                        tid_q      <= sector_number;
                        bit_cnt    <= 3'd0;
                        byte_cnt   <= 16'd0;
                        pend_valid <= 1'b0;
                    end
                end
                HUNT, SHIFT: begin
                    if (sample) begin
                        if (state == HUNT) begin
                            if (data_s) begin
                                shreg   <= 7'd1;
                                bit_cnt <= 3'd1;
                                state   <= SHIFT;
                            end
                        end else begin
                            shreg   <= new_byte[6:0];
                            bit_cnt <= bits_next;
                        end
                    end
                    byte_cnt <= byte_total;
                    if (complete) begin
                        pend_data  <= new_byte;
                        pend_valid <= 1'b1;
                    end
                    if (gate_fall) begin
                        state           <= IDLE;
                        last_byte_count <= byte_total;
                        // A byte finishing on the closing edge leaves one cycle later
                        if (complete) flush      <= 1'b1;
                        else          pend_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // AXI-Stream output register
    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            parallel_tvalid <= 1'b0;
            parallel_tdata  <= 8'd0;
            parallel_tlast  <= 1'b0;
            parallel_tid    <= 8'd0;
        end else if (issue && can_load) begin
            parallel_tvalid <= 1'b1;
            parallel_tdata  <= pend_data;
            parallel_tlast  <= issue_last;
            parallel_tid    <= tid_q;
        end else if (issue && issue_last) begin
            // Final byte cannot be taken: mark the stalled beat as the end
            parallel_tlast <= 1'b1;
        end else if (parallel_tready) begin
            parallel_tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
